window_gen_3x3: RTL
===================

Name: window_gen_3x3

Overview:
- Raster-scan pixel stream to 3x3 neighbourhood generator.
- Accepts one 4-bit pixel per valid cycle, buffers the two previous image lines, and emits a packed 36-bit 3x3 window.
- Output feeds the convolution/averaging stage's 36-bit pixel window input directly.
- Produces only fully interior windows: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame, no padding.

Parameters:
- IMG_WIDTH, 8, pixels per line; must be >= 3.
- IMG_HEIGHT, 8, lines per frame; must be >= 3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- i_pixel  input  4  incoming pixel, raster order (row 0 col 0 first).
- i_pixel_valid  input  1  i_pixel is accepted on every rising edge where this is high; there is no backpressure.
- o_window  output  36  packed window; p_k at bits [4k+3:4k], k = 3*row + col within the window, row-major; p0 = top-left, p8 = bottom-right.
- o_window_valid  output  1  o_window holds a new interior window this cycle.

Behaviour:
- Reset (reset==0 at a clk edge): col/row counters=0, all nine window regs=0, o_window=0, o_window_valid=0.
  - Line-buffer RAM contents are not cleared; they are don't-care because of valid gating.
- Counters:
  - col runs 0..IMG_WIDTH-1; row runs 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and row increments at the end of a line.
  - At col=IMG_WIDTH-1 and row=IMG_HEIGHT-1, both wrap to 0, which starts a new frame.
  - Counter widths are $clog2 of the respective parameter.
- Line buffers: two arrays of depth IMG_WIDTH x 4 bits. lb1[c] holds row r-1 and lb2[c] holds row r-2.
  - On an accepted pixel at column c, read lb2[c] and lb1[c], then write lb2[c]<=lb1[c] and lb1[c]<=i_pixel.
- Window shift: on an accepted pixel, the 3x3 register array shifts left by one column.
  - The new right column is {top=lb2[c], mid=lb1[c], bottom=i_pixel}.
- Valid and latency:
  - o_window_valid=1 for the cycle after an accepting edge with row>=2 and col>=2 (pre-increment values); otherwise 0 on every edge.
  - Latency is 1 cycle from pixel acceptance.
  - The window emitted after pixel (r,c) is centred on (r-1,c-1).
- Gaps: with i_pixel_valid=0, counters, buffers and window regs hold and o_window_valid=0. o_window keeps its last value.
- Back-to-back: continuous input yields o_window_valid high for IMG_WIDTH-2 consecutive cycles per line from row 2 on.
- Line start: stale columns from the previous row in the window regs are never flagged valid, because col<2 gates them.
- Frame wrap:
  - The first pixel of the next frame is row 0, so there are no valid windows until its row 2, col 2.
  - Previous-frame data in the line buffers is never exposed.
- Reset mid-frame: takes effect at the next edge with reset low. The next accepted pixel after release is treated as (0,0).
- Arithmetic: no arithmetic on pixel data; pure storage and routing.

Optional Feature:
- Macro: WINDOW_LAST_EN.
- Defined:
  - Adds output o_last_window (1 bit, reset 0).
  - High for exactly the cycle in which o_window_valid carries the final window of a frame, i.e. after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Low otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 continuous:
  - After pixel 10 is accepted: o_window=36'hA98654210, valid for 1 cycle.
  - After pixel 11: 36'hBA9765321.
  - After 14: 36'hEDCA98654.
  - After 15: 36'hFEDBA9765.
  - Exactly 4 valid cycles in total.
- Same frame with i_pixel_valid low for 3 cycles between pixels 10 and 11: o_window_valid low during the gap and o_window held at 36'hA98654210; the next window is still 36'hBA9765321.
- Two consecutive 4x4 frames (values 0..15, then 15..0): the second frame's first valid window appears only after its 11th pixel (value 5) and equals 36'h5679ABDEF.
- reset=0 for 1 cycle after pixel 9 of frame 1, then resend 0..15: o_window_valid stays 0 until the new pixel 10, which gives 36'hA98654210.
- With WINDOW_LAST_EN defined and the 4x4 frame above: o_last_window=1 only in the cycle with window 36'hFEDBA9765. With the macro undefined, the same stimulus passes the first test unchanged.
- Reset during streaming: o_window=0 and o_window_valid=0 the cycle after the reset edge.

Source files
------------

// File: rtl/window_gen_3x3.sv
// Turns a raster pixel stream into packed 3x3 interior windows, using two line buffers.
// Latency is 1 cycle from an accepted pixel; there is no backpressure. Optional WINDOW_LAST_EN adds o_last_window.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_pixel,
  input  logic        i_pixel_valid,
  output logic [35:0] o_window,
  output logic        o_window_valid
`ifdef WINDOW_LAST_EN
  ,
  output logic        o_last_window
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    lb1 [IMG_WIDTH];
  logic [3:0]    lb2 [IMG_WIDTH];
  logic [3:0]    win [3][3];
  logic [3:0]    lb1_rd;
  logic [3:0]    lb2_rd;
  logic          col_end;
  logic          row_end;
  logic          interior;

  assign lb1_rd   = lb1[col];
  assign lb2_rd   = lb2[col];
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign interior = (row >= ROW_TWO) && (col >= COL_TWO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (i_pixel_valid) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers are never cleared: stale contents are masked by the interior gating.
  always_ff @(posedge clk) begin
    if (reset && i_pixel_valid) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (i_pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= i_pixel;
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < 9; k++) begin
      o_window[4*k +: 4] = win[k/3][k%3];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_window_valid <= 1'b0;
    end else begin
      o_window_valid <= i_pixel_valid && interior;
    end
  end

`ifdef WINDOW_LAST_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_last_window <= 1'b0;
    end else begin
      o_last_window <= i_pixel_valid && row_end && col_end;
    end
  end
`endif

endmodule
